// File: rtl/receptor_display_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : pacote_display                                                 |
// | Opcodes, command FSM states and window defaults of the display receiver  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package pacote_display;

  localparam int LARGURA_PADRAO = 128;
  localparam int PAGINAS_PADRAO = 8;

  localparam int COL_INI_PADRAO = 0;
  localparam int PAG_INI_PADRAO = 0;

  localparam logic [7:0] CMD_MODO_END   = 8'h20;
  localparam logic [7:0] CMD_JANELA_COL = 8'h21;
  localparam logic [7:0] CMD_JANELA_PAG = 8'h22;
  localparam logic [7:0] CMD_CONTRASTE  = 8'h81;
  localparam logic [7:0] CMD_BOMBA      = 8'h8D;
  localparam logic [7:0] CMD_MUX        = 8'hA8;
  localparam logic [7:0] CMD_OFFSET     = 8'hD3;
  localparam logic [7:0] CMD_CLOCK      = 8'hD5;
  localparam logic [7:0] CMD_PRECARGA   = 8'hD9;
  localparam logic [7:0] CMD_PINOS      = 8'hDA;
  localparam logic [7:0] CMD_VCOM       = 8'hDB;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    ARG1   = 2'd1,
    ARG2   = 2'd2
  } estado_t;

  // Commands whose single argument is swallowed without effect on the model
  function automatic logic cmd_tem_um_arg(input logic [7:0] op);
    case (op)
      CMD_MODO_END, CMD_CONTRASTE, CMD_MUX, CMD_OFFSET, CMD_CLOCK,
      CMD_PRECARGA, CMD_PINOS, CMD_VCOM, CMD_BOMBA: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_receptor_bytes.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : spi_receptor_bytes                                             |
// | Synchronizes the 4-wire bus into clk and assembles MSB-first bytes       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module spi_receptor_bytes (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_sclk,
  input  logic       i_sdin,
  input  logic       i_cs,
  input  logic       i_dc,
  input  logic       i_reset_n,
  output logic       o_rst_int,
  output logic       o_byte_valido,
  output logic [7:0] o_byte_rx,
  output logic       o_byte_dc
);

  logic [1:0] r_sclk_s;
  logic [1:0] r_sdin_s;
  logic [1:0] r_cs_s;
  logic [1:0] r_dc_s;
  logic [1:0] r_reset_n_s;
  logic       r_sclk_ant;
  logic [2:0] r_cnt;
  logic [6:0] r_desloc;
  logic       r_valido;
  logic [7:0] r_byte_rx;
  logic       r_byte_dc;
  logic       w_borda;

  // Synchronizers idle at bus-inactive levels so reset never fakes an edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_s    <= 2'b00;
      r_sdin_s    <= 2'b00;
      r_cs_s      <= 2'b11;
      r_dc_s      <= 2'b00;
      r_reset_n_s <= 2'b11;
      r_sclk_ant  <= 1'b0;
    end else begin
      r_sclk_s    <= {r_sclk_s[0], i_sclk};
      r_sdin_s    <= {r_sdin_s[0], i_sdin};
      r_cs_s      <= {r_cs_s[0], i_cs};
      r_dc_s      <= {r_dc_s[0], i_dc};
      r_reset_n_s <= {r_reset_n_s[0], i_reset_n};
      r_sclk_ant  <= r_sclk_s[1];
    end
  end

  assign o_rst_int = rst | ~r_reset_n_s[1];
  assign w_borda   = r_sclk_s[1] & ~r_sclk_ant & ~r_cs_s[1];

  always_ff @(posedge clk) begin
    if (o_rst_int) begin
      r_cnt     <= 3'd0;
      r_desloc  <= 7'd0;
      r_valido  <= 1'b0;
      r_byte_rx <= 8'd0;
      r_byte_dc <= 1'b0;
    end else begin
      r_valido <= 1'b0;
      if (r_cs_s[1]) begin
        r_cnt <= 3'd0;
      end else if (w_borda) begin
        r_desloc <= {r_desloc[5:0], r_sdin_s[1]};
        r_cnt    <= r_cnt + 3'd1;
        if (r_cnt == 3'd7) begin
          r_byte_rx <= {r_desloc, r_sdin_s[1]};
          r_byte_dc <= r_dc_s[1];
          r_valido  <= 1'b1;
        end
      end
    end
  end

  assign o_byte_valido = r_valido;
  assign o_byte_rx     = r_byte_rx;
  assign o_byte_dc     = r_byte_dc;

endmodule
`default_nettype wire

// File: rtl/receptor_display.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : receptor_display                                               |
// | Panel-side model of the SSD1306 bus: command decode and framebuffer      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module receptor_display
  import pacote_display::*;
#(
  parameter int LARGURA = LARGURA_PADRAO,
  parameter int PAGINAS = PAGINAS_PADRAO
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  io_sclk,
  input  logic                                  io_sdin,
  input  logic                                  io_cs,
  input  logic                                  io_dc,
  input  logic                                  io_reset,
  output logic                                  byte_valido,
  output logic [7:0]                            byte_rx,
  output logic                                  byte_dc,
  output logic                                  quadro_completo,
  output logic                                  erro_cmd,
  input  logic [$clog2(LARGURA*PAGINAS)-1:0]    end_leitura,
  output logic [7:0]                            dado_leitura
);

  localparam int COL_W        = $clog2(LARGURA);
  localparam int PAG_W        = $clog2(PAGINAS);
  localparam int END_W        = $clog2(LARGURA*PAGINAS);
  localparam int PROFUNDIDADE = LARGURA * PAGINAS;

  logic             w_rst_int;
  estado_t          r_estado;
  estado_t          w_estado_prox;
  logic [7:0]       r_cmd;
  logic [COL_W-1:0] r_arg1;
  logic [COL_W-1:0] r_col_ini;
  logic [COL_W-1:0] r_col_fim;
  logic [COL_W-1:0] r_col;
  logic [PAG_W-1:0] r_pag_ini;
  logic [PAG_W-1:0] r_pag_fim;
  logic [PAG_W-1:0] r_pag;
  logic             w_erro;
  logic             w_aplica_col;
  logic             w_aplica_pag;
  logic             w_dado;
  logic             w_fim_linha;
  logic [COL_W-1:0] w_col_a;
  logic [COL_W-1:0] w_col_b;
  logic [PAG_W-1:0] w_pag_a;
  logic [PAG_W-1:0] w_pag_b;
  logic [END_W-1:0] w_end_escrita;
  logic [7:0]       r_mem [PROFUNDIDADE];
  logic [7:0]       r_dado_leitura;

  spi_receptor_bytes u_spi (
    .clk           (clk),
    .rst           (rst),
    .i_sclk        (io_sclk),
    .i_sdin        (io_sdin),
    .i_cs          (io_cs),
    .i_dc          (io_dc),
    .i_reset_n     (io_reset),
    .o_rst_int     (w_rst_int),
    .o_byte_valido (byte_valido),
    .o_byte_rx     (byte_rx),
    .o_byte_dc     (byte_dc)
  );

  assign w_col_a     = r_arg1;
  assign w_col_b     = byte_rx[COL_W-1:0];
  assign w_pag_a     = r_arg1[PAG_W-1:0];
  assign w_pag_b     = byte_rx[PAG_W-1:0];
  assign w_dado      = byte_valido & byte_dc;
  assign w_fim_linha = (r_col == r_col_fim);

  always_ff @(posedge clk) begin
    if (w_rst_int) r_estado <= OCIOSO;
    else           r_estado <= w_estado_prox;
  end

  always_comb begin
    w_estado_prox = r_estado;
    w_erro        = 1'b0;
    w_aplica_col  = 1'b0;
    w_aplica_pag  = 1'b0;
    if (byte_valido) begin
      if (byte_dc) begin
        // Data in the middle of a command aborts it; the byte is still stored
        if (r_estado != OCIOSO) begin
          w_erro        = 1'b1;
          w_estado_prox = OCIOSO;
        end
      end else begin
        case (r_estado)
          OCIOSO: begin
            if (byte_rx == CMD_JANELA_COL || byte_rx == CMD_JANELA_PAG ||
                cmd_tem_um_arg(byte_rx))
              w_estado_prox = ARG1;
          end
          ARG1: begin
            if (r_cmd == CMD_JANELA_COL || r_cmd == CMD_JANELA_PAG)
              w_estado_prox = ARG2;
            else
              w_estado_prox = OCIOSO;
          end
          ARG2: begin
            w_estado_prox = OCIOSO;
            if (r_cmd == CMD_JANELA_COL) begin
              if (w_col_a > w_col_b) w_erro       = 1'b1;
              else                   w_aplica_col = 1'b1;
            end else begin
              if (w_pag_a > w_pag_b) w_erro       = 1'b1;
              else                   w_aplica_pag = 1'b1;
            end
          end
          default: w_estado_prox = OCIOSO;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_rst_int) begin
      r_cmd  <= 8'd0;
      r_arg1 <= '0;
    end else if (byte_valido && !byte_dc) begin
      if (r_estado == OCIOSO) r_cmd  <= byte_rx;
      if (r_estado == ARG1)   r_arg1 <= byte_rx[COL_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (w_rst_int) begin
      r_col_ini <= COL_W'(COL_INI_PADRAO);
      r_col_fim <= COL_W'(LARGURA - 1);
      r_pag_ini <= PAG_W'(PAG_INI_PADRAO);
      r_pag_fim <= PAG_W'(PAGINAS - 1);
      r_col     <= COL_W'(COL_INI_PADRAO);
      r_pag     <= PAG_W'(PAG_INI_PADRAO);
    end else if (w_aplica_col) begin
      r_col_ini <= w_col_a;
      r_col_fim <= w_col_b;
      r_col     <= w_col_a;
      r_pag     <= r_pag_ini;
    end else if (w_aplica_pag) begin
      r_pag_ini <= w_pag_a;
      r_pag_fim <= w_pag_b;
      r_pag     <= w_pag_a;
      r_col     <= r_col_ini;
    end else if (w_dado) begin
      if (!w_fim_linha) begin
        r_col <= r_col + COL_W'(1);
      end else begin
        r_col <= r_col_ini;
        if (r_pag == r_pag_fim) r_pag <= r_pag_ini;
        else                    r_pag <= r_pag + PAG_W'(1);
      end
    end
  end

  assign erro_cmd        = w_erro;
  assign quadro_completo = w_dado & w_fim_linha & (r_pag == r_pag_fim);
  assign w_end_escrita   = END_W'(int'(r_pag) * LARGURA + int'(r_col));

  // Framebuffer survives reset; only the read register is cleared
  always_ff @(posedge clk) begin
    if (w_dado) r_mem[w_end_escrita] <= byte_rx;
  end

  always_ff @(posedge clk) begin
    if (w_rst_int) r_dado_leitura <= 8'd0;
    else           r_dado_leitura <= r_mem[end_leitura];
  end

  assign dado_leitura = r_dado_leitura;

endmodule
`default_nettype wire
